// File: rtl/sram_scan_pkg.sv
// sram_scan_pkg: scan frame layout, FSM state codes and command frame packing
package sram_scan_pkg;
  localparam int FRAME_W = 112;
  localparam int SEL_MSB = 111;
  localparam int SEL_LSB = 108;
  localparam int ADDR0_MSB = 107;
  localparam int ADDR0_LSB = 92;
  localparam int DIN0_MSB = 91;
  localparam int DIN0_LSB = 60;
  localparam int CSB0 = 59;
  localparam int WEB0 = 58;
  localparam int ADDR1_MSB = 53;
  localparam int ADDR1_LSB = 38;
  localparam int DIN1_MSB = 37;
  localparam int DIN1_LSB = 6;
  localparam int CSB1 = 5;
  localparam int WEB1 = 4;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SHIFT_IN = 3'd1;
  localparam logic [2:0] ACCESS = 3'd2;
  localparam logic [2:0] GAP = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] LOAD = 3'd5;
  localparam logic [2:0] SHIFT_OUT = 3'd6;
  localparam logic [2:0] DONE = 3'd7;
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [3:0] sel,
    input logic [15:0] addr0,
    input logic [31:0] din0,
    input logic csb0,
    input logic web0,
    input logic [15:0] addr1,
    input logic [31:0] din1,
    input logic csb1,
    input logic web1
  );
    return {sel, addr0, din0, csb0, web0, 4'hF, addr1, din1, csb1, web1, 4'hF};
  endfunction
endpackage

// File: rtl/sram_scan_shreg.sv
// sram_scan_shreg: rotating tx frame register, rx capture register and bit counter
module sram_scan_shreg
  import sram_scan_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic               tx_shift,
  input  logic               rx_shift,
  input  logic               cnt_clr,
  input  logic               scan_out,
  input  logic [FRAME_W-1:0] frame_in,
  output logic [FRAME_W-1:0] tx_frame,
  output logic [FRAME_W-1:0] rx_frame,
  output logic [6:0]         cnt,
  output logic               tc
);
  logic [FRAME_W-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [6:0] cnt_q, cnt_d;
  always_comb begin
    tx_d = load ? frame_in : tx_shift ? {tx_q[FRAME_W-2:0], tx_q[FRAME_W-1]} : tx_q;
    rx_d = load ? '0 : rx_shift ? {rx_q[FRAME_W-2:0], scan_out} : rx_q;
    cnt_d = cnt_clr ? '0 : cnt_q + 7'd1;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_q <= '0;
      rx_q <= '0;
      cnt_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
      cnt_q <= cnt_d;
    end
  end
  assign tx_frame = tx_q;
  assign rx_frame = rx_q;
  assign cnt = cnt_q;
  assign tc = cnt_q == 7'(FRAME_W - 1);
endmodule

// File: rtl/sram_scan_sequencer.sv
// sram_scan_sequencer: serialises SRAM commands onto the harness scan chain and returns the read-back frame
module sram_scan_sequencer
  import sram_scan_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_read,
  input  logic [FRAME_W-1:0] cmd_frame,
  output logic               scan_in,
  output logic               scan_en,
  output logic               sram_load,
  output logic               global_csb,
  input  logic               scan_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [FRAME_W-1:0] rsp_frame,
  output logic [31:0]        rsp_dout0,
  output logic [31:0]        rsp_dout1,
  output logic               rsp_echo_err,
  output logic               rsp_data_err,
  output logic               busy
);
  logic [2:0] state_q, state_d;
  logic read_q, read_d, rsp_valid_q, rsp_valid_d;
  logic echo_err_q, echo_err_d, data_err_q, data_err_d;
  logic [FRAME_W-1:0] rsp_frame_q, rsp_frame_d, tx_frame, rx_frame, echo_mask;
  logic [6:0] cnt;
  logic tc, accept, capture, gap_done, rd0, rd1;
  assign accept = state_q == IDLE && cmd_valid;
  assign capture = state_q == DONE && !rsp_valid_q;
  assign gap_done = cnt == 7'(GAP_CYCLES - 1);
  assign rd0 = !tx_frame[CSB0] && tx_frame[WEB0];
  assign rd1 = !tx_frame[CSB1] && tx_frame[WEB1];
  sram_scan_shreg u_shreg (
    .clk      (clk),
    .resetn   (resetn),
    .load     (accept),
    .tx_shift (state_q == SHIFT_IN),
    .rx_shift (state_q == SHIFT_OUT),
    .cnt_clr  (accept || state_q == ACCESS || state_q == LOAD),
    .scan_out (scan_out),
    .frame_in (cmd_frame),
    .tx_frame (tx_frame),
    .rx_frame (rx_frame),
    .cnt      (cnt),
    .tc       (tc)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = cmd_valid ? SHIFT_IN : IDLE;
      SHIFT_IN:  state_d = tc ? ACCESS : SHIFT_IN;
      ACCESS:    state_d = read_q ? CAPTURE : GAP;
      GAP:       state_d = gap_done ? DONE : GAP;
      CAPTURE:   state_d = gap_done ? LOAD : CAPTURE;
      LOAD:      state_d = SHIFT_OUT;
      SHIFT_OUT: state_d = tc ? DONE : SHIFT_OUT;
      DONE:      state_d = rsp_valid_q && rsp_ready ? IDLE : DONE;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    echo_mask = '1;
    if (rd0) echo_mask[DIN0_MSB:DIN0_LSB] = '0;
    if (rd1) echo_mask[DIN1_MSB:DIN1_LSB] = '0;
    read_d = accept ? cmd_read : read_q;
    rsp_valid_d = capture || (rsp_valid_q && !rsp_ready);
    rsp_frame_d = capture ? rx_frame : rsp_frame_q;
    echo_err_d = capture ? read_q && |((rx_frame ^ tx_frame) & echo_mask) : echo_err_q;
    data_err_d = capture ? read_q && ((rd0 && rx_frame[DIN0_MSB:DIN0_LSB] != tx_frame[DIN0_MSB:DIN0_LSB]) ||
                                      (rd1 && rx_frame[DIN1_MSB:DIN1_LSB] != tx_frame[DIN1_MSB:DIN1_LSB]))
                         : data_err_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      read_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_frame_q <= '0;
      echo_err_q <= 1'b0;
      data_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      read_q <= read_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_frame_q <= rsp_frame_d;
      echo_err_q <= echo_err_d;
      data_err_q <= data_err_d;
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign scan_en = state_q == SHIFT_IN || state_q == SHIFT_OUT;
  assign scan_in = state_q == SHIFT_IN && tx_frame[FRAME_W-1];
  assign sram_load = state_q == LOAD;
  assign global_csb = state_q != ACCESS;
  assign rsp_valid = rsp_valid_q;
  assign rsp_frame = rsp_frame_q;
  assign rsp_dout0 = rsp_frame_q[DIN0_MSB:DIN0_LSB];
  assign rsp_dout1 = rsp_frame_q[DIN1_MSB:DIN1_LSB];
  assign rsp_echo_err = echo_err_q;
  assign rsp_data_err = data_err_q;
endmodule
